// File: rtl/ising_run_ctrl.sv
// Ising run sequencer: reset hold, timed anneal, phase sampling to spins.
// Optional RUN_CTRL_IRQ_EN adds CTRL bit2 irq enable and an irq output.
module ising_run_ctrl #(
  parameter int          N           = 8,
  parameter int          CNT_W       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
  parameter int          RUN_RST     = 1000,
  parameter int          SAMPLE_RST  = 256
) (
  input  logic          clk,
  input  logic          axi_rst,
  input  logic          wready,
  input  logic [31:0]   wr_addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rdata,
  input  logic [N-1:0]  osc_in,
  output logic          ising_rstn,
  output logic          busy,
  output logic          done
`ifdef RUN_CTRL_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int NW = (N + 31) / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_run_cycles;
  logic [CNT_W-1:0]       r_smp_cycles;
  logic [CNT_W-1:0]       r_run_lim;
  logic [CNT_W-1:0]       r_smp_lim;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_mis [N];
  logic [N-1:0]           r_spins;
  logic [N-1:0]           r_sync [SYNC_STAGES];
  logic [N-1:0]           w_sync;
  logic                   w_wr_sel;
  logic [5:0]             w_wr_word;
  logic                   w_ctrl_wr;
  logic                   w_start;
  logic                   w_abort;
  logic                   w_done_clr;
  logic [5:0]             w_rd_word;
  logic [31:0]            w_rd_data;
  logic [NW*32-1:0]       w_spins_pad;
  logic                   w_irq_en;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_wr_sel   = wready && (wr_addr[31:8] == BASE_ADDR[31:8]);
  assign w_wr_word  = wr_addr[7:2];
  assign w_ctrl_wr  = w_wr_sel && (w_wr_word == 6'd0);
  assign w_abort    = w_ctrl_wr && wdata[1];
  assign w_start    = w_ctrl_wr && wdata[0] && !wdata[1];
  assign w_done_clr = w_wr_sel && (w_wr_word == 6'd3) && wdata[1];
  assign w_rd_word  = rd_addr[7:2];
  assign w_spins_pad = (NW*32)'(r_spins);

  // Multi-flop synchroniser for the free-running oscillator outputs
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= osc_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // Software-visible configuration registers
`ifdef RUN_CTRL_IRQ_EN
  logic r_irq_en;
  assign w_irq_en = r_irq_en;
  assign irq      = done & r_irq_en;
`else
  assign w_irq_en = 1'b0;
`endif

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_run_cycles <= CNT_W'(RUN_RST);
      r_smp_cycles <= CNT_W'(SAMPLE_RST);
`ifdef RUN_CTRL_IRQ_EN
      r_irq_en     <= 1'b0;
`endif
    end else begin
      if (w_wr_sel && (w_wr_word == 6'd1)) r_run_cycles <= CNT_W'(wdata);
      if (w_wr_sel && (w_wr_word == 6'd2)) r_smp_cycles <= CNT_W'(wdata);
`ifdef RUN_CTRL_IRQ_EN
      if (w_ctrl_wr) r_irq_en <= wdata[2];
`endif
    end
  end

  // Run sequencer: state, registered outputs, counters and spin results
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_state    <= S_IDLE;
      ising_rstn <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      r_run_lim  <= '0;
      r_smp_lim  <= '0;
      r_cnt      <= '0;
      r_spins    <= '0;
      for (int i = 0; i < N; i++) r_mis[i] <= '0;
    end else begin
      if (w_done_clr) done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_RUN;
            ising_rstn <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            r_run_lim  <= r_run_cycles;
            r_smp_lim  <= r_smp_cycles;
            r_cnt      <= '0;
            for (int i = 0; i < N; i++) r_mis[i] <= '0;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state    <= S_IDLE;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
          end else if (r_run_lim == '0 ||
                       r_cnt == r_run_lim - CNT_W'(1)) begin
            r_state <= S_SAMPLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          if (w_abort) begin
            r_state    <= S_IDLE;
            ising_rstn <= 1'b0;
            busy       <= 1'b0;
          end else if (r_smp_lim == '0) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
          end else begin
            for (int i = 0; i < N; i++)
              r_mis[i] <= r_mis[i] + CNT_W'(w_sync[i] ^ w_sync[0]);
            if (r_cnt == r_smp_lim - CNT_W'(1)) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          for (int i = 0; i < N; i++)
            r_spins[i] <= (i != 0) && (r_mis[i] > (r_smp_lim >> 1));
          done       <= 1'b1;
          ising_rstn <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read decode for the register window
  always_comb begin
    w_rd_data = '0;
    if (rd_addr[31:8] == BASE_ADDR[31:8]) begin
      unique case (w_rd_word)
        6'd0: w_rd_data = {29'b0, w_irq_en, 2'b0};
        6'd1: w_rd_data = 32'(r_run_cycles);
        6'd2: w_rd_data = 32'(r_smp_cycles);
        6'd3: w_rd_data = {30'b0, done, busy};
        default: begin
          for (int k = 0; k < NW; k++)
            if (w_rd_word == 6'(4 + k))
              w_rd_data = w_spins_pad[k*32 +: 32];
        end
      endcase
    end
  end

  // Registered read port, one cycle behind rd_addr
  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) rdata <= '0;
    else         rdata <= w_rd_data;
  end

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl.
// Covers reset, sequencing, spin reduction, abort, zero limits, irq.
`timescale 1ns/1ps
module tb_ising_run_ctrl;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          axi_rst = 1'b1;
  logic          wready = 1'b0;
  logic [31:0]   wr_addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rd_addr = '0;
  logic [31:0]   rdata;
  logic [N-1:0]  osc_in;
  logic          ising_rstn;
  logic          busy;
  logic          done;
`ifdef RUN_CTRL_IRQ_EN
  logic          irq;
`endif

  logic          base = 1'b0;
  logic [N-1:0]  inv_mask = '0;
  int            checks = 0;
  int            errors = 0;
  int            hi_cnt = 0;

  assign osc_in = {N{base}} ^ inv_mask;

  ising_run_ctrl #(.N(N)) dut (
    .clk(clk),
    .axi_rst(axi_rst),
    .wready(wready),
    .wr_addr(wr_addr),
    .wdata(wdata),
    .rd_addr(rd_addr),
    .rdata(rdata),
    .osc_in(osc_in),
    .ising_rstn(ising_rstn),
    .busy(busy),
    .done(done)
`ifdef RUN_CTRL_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;
  always #17 base = ~base;

  always @(posedge clk) if (ising_rstn) hi_cnt++;

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    wready  = 1'b1;
    wr_addr = 32'h100 + {24'b0, off};
    wdata   = d;
    @(negedge clk);
    wready  = 1'b0;
    wr_addr = '0;
    wdata   = '0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    rd_addr = 32'h100 + {24'b0, off};
    @(negedge clk);
    d = rdata;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!ising_rstn) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #12;
    checks++; if (ising_rstn !== 1'b0) begin errors++;
      $display("FAIL rst_rstn got %b want 0", ising_rstn); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", done); end
    checks++; if (rdata !== 32'h0) begin errors++;
      $display("FAIL rst_rdata got %h want 0", rdata); end
    @(negedge clk);
    axi_rst = 1'b0;
    @(negedge clk);
    rd_addr = 32'h104;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++;
      $display("FAIL rd_latency_early got %0d want 0", rdata); end
    @(negedge clk);
    checks++; if (rdata !== 32'd1000) begin errors++;
      $display("FAIL rd_run_rst got %0d want 1000", rdata); end
    rd(8'h08, d);
    checks++; if (d !== 32'd256) begin errors++;
      $display("FAIL rd_smp_rst got %0d want 256", d); end
  endtask

  task automatic test_in_phase;
    logic [31:0] d;
    int h0;
    bit ok;
    inv_mask = '0;
    wr(8'h04, 32'd10);
    wr(8'h08, 32'd16);
    h0 = hi_cnt;
    wr(8'h00, 32'h1);
    checks++; if (busy !== 1'b1 || ising_rstn !== 1'b1) begin errors++;
      $display("FAIL run_start busy %b rstn %b want 1 1", busy, ising_rstn); end
    wait_end(ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL run_timeout got 0 want 1"); end
    checks++; if (hi_cnt - h0 !== 27) begin errors++;
      $display("FAIL run_hi_cycles got %0d want 27", hi_cnt - h0); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL run_done done %b busy %b want 1 0", done, busy); end
    rd(8'h10, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL run_spins got %h want 0", d); end
  endtask

  task automatic test_spins;
    logic [31:0] d;
    bit ok;
    inv_mask = 8'h28;
    wr(8'h08, 32'd64);
    wr(8'h00, 32'h1);
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1) begin errors++;
      $display("FAIL spin_end ok %b done %b want 1 1", ok, done); end
    rd(8'h10, d);
    checks++; if (d !== 32'h28) begin errors++;
      $display("FAIL spin_val got %h want 00000028", d); end
    rd(8'h0C, d);
    checks++; if (d !== 32'h2) begin errors++;
      $display("FAIL spin_status got %h want 2", d); end
  endtask

  task automatic test_abort;
    logic [31:0] d;
    wr(8'h04, 32'd20);
    wr(8'h00, 32'h1);
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL abort_pre busy got %b want 1", busy); end
    wr(8'h00, 32'h2);
    checks++; if (ising_rstn !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_stop rstn %b busy %b want 0 0", ising_rstn, busy); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL abort_done got %b want 0", done); end
    rd(8'h10, d);
    checks++; if (d !== 32'h28) begin errors++;
      $display("FAIL abort_spins got %h want 00000028", d); end
  endtask

  task automatic test_zero_limits;
    logic [31:0] d;
    int h0;
    bit ok;
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd0);
    h0 = hi_cnt;
    wr(8'h00, 32'h1);
    wait_end(ok);
    checks++; if (!ok || hi_cnt - h0 !== 3) begin errors++;
      $display("FAIL zero_hi got %0d want 3", hi_cnt - h0); end
    checks++; if (done !== 1'b1) begin errors++;
      $display("FAIL zero_done got %b want 1", done); end
    rd(8'h10, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL zero_spins got %h want 0", d); end
    wr(8'h0C, 32'h2);
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL done_clear got %b want 0", done); end
    rd(8'h0C, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL status_clear got %h want 0", d); end
  endtask

  task automatic test_start_busy;
    int h0;
    bit ok;
    wr(8'h04, 32'd2);
    wr(8'h08, 32'd40);
    h0 = hi_cnt;
    wr(8'h00, 32'h1);
    repeat (6) @(negedge clk);
    wr(8'h00, 32'h1);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL busy_start busy got %b want 1", busy); end
    wait_end(ok);
    checks++; if (!ok || hi_cnt - h0 !== 43) begin errors++;
      $display("FAIL busy_start_hi got %0d want 43", hi_cnt - h0); end
    wr(8'h00, 32'h3);
    checks++; if (busy !== 1'b0 || ising_rstn !== 1'b0) begin errors++;
      $display("FAIL idle_3 busy %b rstn %b want 0 0", busy, ising_rstn); end
    checks++; if (done !== 1'b1) begin errors++;
      $display("FAIL idle_3_done got %b want 1", done); end
  endtask

  task automatic test_map;
    logic [31:0] d;
    wr(8'h04, 32'd123);
    wr(8'h40, 32'd77);
    rd(8'h04, d);
    checks++; if (d !== 32'd123) begin errors++;
      $display("FAIL map_run got %0d want 123", d); end
    rd(8'h14, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL map_spin1 got %h want 0", d); end
    rd(8'h40, d);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL map_unmapped got %h want 0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic [31:0] exp_ctrl;
    bit ok;
`ifdef RUN_CTRL_IRQ_EN
    exp_ctrl = 32'h4;
`else
    exp_ctrl = 32'h0;
`endif
    wr(8'h04, 32'd3);
    wr(8'h08, 32'd4);
    wr(8'h00, 32'h5);
    wait_end(ok);
    checks++; if (!ok || done !== 1'b1) begin errors++;
      $display("FAIL irq_run ok %b done %b want 1 1", ok, done); end
    rd(8'h00, d);
    checks++; if (d !== exp_ctrl) begin errors++;
      $display("FAIL ctrl_read got %h want %h", d, exp_ctrl); end
`ifdef RUN_CTRL_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++;
      $display("FAIL irq_set got %b want 1", irq); end
    wr(8'h0C, 32'h2);
    checks++; if (irq !== 1'b0) begin errors++;
      $display("FAIL irq_clear got %b want 0", irq); end
`endif
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    wr(8'h04, 32'd50);
    wr(8'h00, 32'h1);
    repeat (3) @(negedge clk);
    #2 axi_rst = 1'b1;
    #1;
    checks++; if (ising_rstn !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL arst_outs rstn %b busy %b want 0 0", ising_rstn, busy); end
    checks++; if (done !== 1'b0 || rdata !== 32'h0) begin errors++;
      $display("FAIL arst_done done %b rdata %h want 0 0", done, rdata); end
    @(negedge clk);
    axi_rst = 1'b0;
    rd(8'h04, d);
    checks++; if (d !== 32'd1000) begin errors++;
      $display("FAIL arst_run got %0d want 1000", d); end
  endtask

  initial begin
    test_reset();
    test_in_phase();
    test_spins();
    test_abort();
    test_zero_limits();
    test_start_busy();
    test_map();
    test_irq();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
